writeback_arbiter: RTL

- Shares the single register-file write port between NUM_REQ result producers, e.g. the memory/ALU path and long-latency units.
- Sits between the producers and the register fetch stage, and drives the `writeback_rfetch_*` write interface.
- Each cycle, grants at most one valid requester, registers its destination and data, and presents the write one cycle later.

---
 rtl/rvga_types.sv | 16 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/writeback_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/rvga_types.sv
// Shared RV-GA pipeline types, plus the write-back requester bundle and the
// default requester count used by the write-back arbiter.
package rvga_types;

  typedef logic [31:0] rvga_word;
  typedef logic [4:0]  rvga_reg;

  typedef struct packed {
    logic     v;
    rvga_reg  rd;
    rvga_word data;
  } rvga_wb_req_t;

  localparam int RVGA_WRITEARB_NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Find-first-from-pointer arbiter with its rotating pointer.
// With WRITEARB_RR_EN undefined the pointer is tied to 0, giving fixed priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_v
);

  logic [PTR_W-1:0] ptr;

  // Two passes: first look at indices at or above the pointer, then wrap to
  // the ones below it; no modular arithmetic is needed for odd NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_v   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_v && req[i] && (i >= int'(ptr))) begin
        grant_v   = 1'b1;
        grant_idx = PTR_W'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_v && req[i]) begin
        grant_v   = 1'b1;
        grant_idx = PTR_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end

`ifdef WRITEARB_RR_EN
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_v) begin
      ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign ptr = '0;
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between NUM_REQ producers and registers
// the winning write. Define WRITEARB_RR_EN for round-robin, else fixed priority.
module writeback_arbiter
  import rvga_types::*;
#(
  parameter int NUM_REQ = RVGA_WRITEARB_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      writearb_req_v,
  input  rvga_reg  [NUM_REQ-1:0]  writearb_req_rd,
  input  rvga_word [NUM_REQ-1:0]  writearb_req_data,
  output logic [NUM_REQ-1:0]      writearb_req_ready,
  input  logic                    rfetch_writearb_stall,
  output logic                    writeback_rfetch_rd_w_v,
  output rvga_reg                 writeback_rfetch_rd,
  output rvga_word                writeback_rfetch_rd_data,
  output logic                    writearb_busy
);

  rvga_wb_req_t [NUM_REQ-1:0] reqs;
  rvga_wb_req_t               sel;
  logic [NUM_REQ-1:0]         eligible;
  logic [NUM_REQ-1:0]         grant;
  logic [PTR_W-1:0]           grant_idx;
  logic                       grant_v;
  logic                       xfer;

  always_comb begin
    reqs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].v    = writearb_req_v[i];
      reqs[i].rd   = writearb_req_rd[i];
      reqs[i].data = writearb_req_data[i];
    end
  end

  // Reset and stall both hide every request from the arbiter, so the pointer
  // cannot move and no ready bit can rise.
  assign eligible = writearb_req_v & {NUM_REQ{~(rfetch_writearb_stall | rst)}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_v   (grant_v)
  );

  assign writearb_req_ready = grant;
  assign sel  = reqs[grant_idx];
  assign xfer = grant_v & sel.v;

  // A granted x0 request still loads rd/data but never raises the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeback_rfetch_rd_w_v  <= 1'b0;
      writeback_rfetch_rd      <= '0;
      writeback_rfetch_rd_data <= '0;
      writearb_busy            <= 1'b0;
    end else begin
      writearb_busy <= |(writearb_req_v & ~grant);
      if (xfer) begin
        writeback_rfetch_rd_w_v  <= (sel.rd != '0);
        writeback_rfetch_rd      <= sel.rd;
        writeback_rfetch_rd_data <= sel.data;
      end else begin
        writeback_rfetch_rd_w_v  <= 1'b0;
      end
    end
  end

endmodule
